mem_arbiter: RTL and testbench

- Sequences and shares the single unified instruction/data memory of the multicycle MIPS core between two requesters: the CPU control path (fetch, lw, sw) and a debug/loader port used to preload and inspect memory.
- Issues one memory transaction at a time, absorbs the memory read latency, and stalls the CPU control FSM until its access completes.
- Sits between the control/datapath memory signals and the memory macro.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters (CPU control path, debug/loader port),
// the arbiter and the memory macro. The arbiter uses the slave view; the
// requester/memory side uses the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the unified instruction/data memory between the CPU control path and
// the debug/loader port. One transaction at a time; read latency is absorbed
// by a down-counter, and the CPU is stalled until its own access completes.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample requests, pick a winner, latch its command
// ACCESS | single-cycle memory strobe with the latched command
// WAIT   | count down the read latency, capture read data at zero
// DONE   | one-cycle ack to the owner, then back to IDLE
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int FAIR_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            nextState;

    logic              latWe;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latWdata;
    logic              ownerReg;
    logic [3:0]        starveCnt;
    logic [3:0]        latCnt;
    logic [DATA_W-1:0] cpuRdataReg;
    logic [DATA_W-1:0] dbgRdataReg;

    logic              dbgWins;
    logic              cpuWins;
    logic              grant;

    // Arbitration: debug takes the slot when the CPU is quiet or has hogged it.
    always_comb begin
        dbgWins = bus.dbg_req & (~bus.cpu_req | (starveCnt >= 4'(FAIR_LIMIT)));
        cpuWins = bus.cpu_req & ~dbgWins;
        grant   = (state == IDLE) & (dbgWins | cpuWins);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and memory-side / ack outputs; everything defaults to idle.
    always_comb begin
        nextState     = state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cpu_ack   = 1'b0;
        bus.dbg_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (dbgWins || cpuWins) begin
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = latWe;
                bus.mem_addr  = latAddr;
                bus.mem_wdata = latWdata;
                nextState     = latWe ? DONE : WAIT;
            end
            WAIT: begin
                if (latCnt == 4'd0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                bus.cpu_ack = ~ownerReg;
                bus.dbg_ack = ownerReg;
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Latch the winner's command and update the starvation counter at grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            latWe     <= 1'b0;
            latAddr   <= '0;
            latWdata  <= '0;
            ownerReg  <= 1'b0;
            starveCnt <= 4'd0;
        end else if (grant) begin
            ownerReg <= dbgWins;
            latWe    <= dbgWins ? bus.dbg_we    : bus.cpu_we;
            latAddr  <= dbgWins ? bus.dbg_addr  : bus.cpu_addr;
            latWdata <= dbgWins ? bus.dbg_wdata : bus.cpu_wdata;
            if (dbgWins || !bus.dbg_req) begin
                starveCnt <= 4'd0;
            end else if (starveCnt < 4'(FAIR_LIMIT)) begin
                starveCnt <= starveCnt + 4'd1;
            end
        end
    end

    // Read-latency down-counter: loaded on a read strobe, terminal count at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            latCnt <= 4'd0;
        end else if (state == ACCESS && !latWe) begin
            latCnt <= 4'(MEM_LAT - 1);
        end else if (state == WAIT && latCnt != 4'd0) begin
            latCnt <= latCnt - 4'd1;
        end
    end

    // Read data capture into the owner's register; held across everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpuRdataReg <= '0;
            dbgRdataReg <= '0;
        end else if (state == WAIT && latCnt == 4'd0) begin
            if (ownerReg) begin
                dbgRdataReg <= bus.mem_rdata;
            end else begin
                cpuRdataReg <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_rdata = cpuRdataReg;
    assign bus.dbg_rdata = dbgRdataReg;
    assign bus.owner     = ownerReg;
    assign bus.busy      = (state != IDLE);
    assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, checked against a transaction-level model of grants and memory.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int FL  = 4;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT),
        .FAIR_LIMIT(FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] initVal(input logic [7:0] a);
        return {a, 8'h5A, ~a, 8'hC3};
    endfunction

    // Memory macro: fixed read latency, junk on the pipe when not strobed.
    logic [31:0] macMem [0:255];
    logic [31:0] rdPipe [0:LAT-1];
    logic        memLoaded = 1'b0;

    assign bus.mem_rdata = rdPipe[LAT-1];

    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) macMem[i] <= initVal(8'(i));
            memLoaded <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            macMem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        rdPipe[0] <= bus.mem_en ? macMem[bus.mem_addr[7:0]] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end

    // Reference model state.
    logic [31:0] refMem [0:255];
    int          mStarve;
    logic [31:0] expCpu;
    logic [31:0] expDbg;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 if debug is granted; tracks consecutive CPU grants over a waiting debug.
    function automatic bit modelGrant(input bit cpuP, input bit dbgP);
        bit d;
        d = dbgP && (!cpuP || mStarve >= FL);
        if (d || !dbgP) mStarve = 0;
        else if (mStarve < FL) mStarve++;
        return d;
    endfunction

    function automatic void modelComplete(input bit isDbg, input bit we,
                                          input logic [31:0] a, input logic [31:0] d);
        if (we) refMem[a[7:0]] = d;
        else if (isDbg) expDbg = refMem[a[7:0]];
        else expCpu = refMem[a[7:0]];
    endfunction

    task automatic drivePort(input bit isDbg, input bit req, input bit we,
                             input logic [31:0] a, input logic [31:0] d);
        if (isDbg) begin
            bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
    endtask

    task automatic checkRdata(input string tag);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, expCpu);
        chk({tag, "_dbg_rdata"}, bus.dbg_rdata, expDbg);
    endtask

    // One transaction from a single port, other port idle; checks strobe and ack timing.
    task automatic singleTxn(input bit isDbg, input bit we, input logic [31:0] a,
                             input logic [31:0] d, input bit scramble);
        int enCnt, enOff, ackOff, otherAck;
        logic [31:0] enAddr, enWdata;
        logic enWe;
        bit win;
        enCnt = 0; enOff = -1; ackOff = -1; otherAck = 0;
        enAddr = '0; enWdata = '0; enWe = 1'b0;
        win = modelGrant(!isDbg, isDbg);
        drivePort(isDbg, 1'b1, we, a, d);
        for (int k = 1; k <= 30 && ackOff < 0; k++) begin
            tick();
            if (bus.mem_en) begin
                enCnt++; enOff = k;
                enAddr = bus.mem_addr; enWe = bus.mem_we; enWdata = bus.mem_wdata;
            end
            if (isDbg ? bus.cpu_ack : bus.dbg_ack) otherAck++;
            if (!isDbg && k == 1) chk("stall_pending", 32'(bus.cpu_stall), 32'd1);
            if (scramble && k == 2) drivePort(isDbg, 1'b1, we, a ^ 32'h0000_00C0, ~d);
            if (isDbg ? bus.dbg_ack : bus.cpu_ack) begin
                ackOff = k;
                chk("owner_at_ack", 32'(bus.owner), 32'(win));
                if (!isDbg) chk("stall_at_ack", 32'(bus.cpu_stall), 32'd0);
                drivePort(isDbg, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        if (ackOff < 0) drivePort(isDbg, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("mem_en_count", 32'(enCnt), 32'd1);
        chk("mem_en_cycle", 32'(enOff), 32'd1);
        chk("ack_cycle", 32'(ackOff), we ? 32'd2 : 32'(2 + LAT));
        chk("mem_addr", enAddr, a);
        chk("mem_we", 32'(enWe), 32'(we));
        if (we) chk("mem_wdata", enWdata, d);
        chk("other_ack", 32'(otherAck), 32'd0);
        tick();
        chk("ack_one_cycle", {30'd0, bus.cpu_ack, bus.dbg_ack}, 32'd0);
        chk("idle_after_done", {30'd0, bus.busy, bus.mem_en}, 32'd0);
        modelComplete(isDbg, we, a, d);
        checkRdata("single");
    endtask

    // Both ports (or one) request together; each must get exactly one ack in model order.
    task automatic pairRound(input bit cpuOn, input bit dbgOn,
                             input bit cWe, input logic [31:0] cA, input logic [31:0] cD,
                             input bit dWe, input logic [31:0] dA, input logic [31:0] dD);
        bit w1;
        bit w2;
        int cAcks, dAcks, first;
        w1 = modelGrant(cpuOn, dbgOn);
        w2 = w1;
        if (cpuOn && dbgOn) w2 = modelGrant(w1, !w1);
        cAcks = 0; dAcks = 0; first = -1;
        drivePort(1'b0, cpuOn, cWe, cA, cD);
        drivePort(1'b1, dbgOn, dWe, dA, dD);
        for (int k = 0; k < 60 && (bus.cpu_req || bus.dbg_req); k++) begin
            tick();
            if (bus.cpu_ack) begin
                cAcks++;
                if (first < 0) first = 0;
                chk("pair_owner_cpu", 32'(bus.owner), 32'd0);
                drivePort(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            if (bus.dbg_ack) begin
                dAcks++;
                if (first < 0) first = 1;
                chk("pair_owner_dbg", 32'(bus.owner), 32'd1);
                drivePort(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            end
        end
        drivePort(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drivePort(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("pair_cpu_acks", 32'(cAcks), 32'(cpuOn));
        chk("pair_dbg_acks", 32'(dAcks), 32'(dbgOn));
        chk("pair_first", 32'(first), 32'(w1));
        tick();
        chk("pair_idle", {30'd0, bus.busy, bus.cpu_ack | bus.dbg_ack}, 32'd0);
        if (w1) modelComplete(1'b1, dWe, dA, dD);
        else    modelComplete(1'b0, cWe, cA, cD);
        if (cpuOn && dbgOn) begin
            if (w2) modelComplete(1'b1, dWe, dA, dD);
            else    modelComplete(1'b0, cWe, cA, cD);
        end
        checkRdata("pair");
    endtask

    // Both ports hold write requests for n grants; checks grant order and spacing.
    task automatic holdBoth(input int n, input logic [31:0] cA, input logic [31:0] cD,
                            input logic [31:0] dA, input logic [31:0] dD, input bit fixedPat);
        bit expSeq[$];
        int got, last, k;
        bit who;
        for (int i = 0; i < n; i++) expSeq.push_back(modelGrant(1'b1, 1'b1));
        got = 0; last = -1; k = 0;
        drivePort(1'b0, 1'b1, 1'b1, cA, cD);
        drivePort(1'b1, 1'b1, 1'b1, dA, dD);
        while (got < n && k < 300) begin
            tick();
            k++;
            if (bus.cpu_ack || bus.dbg_ack) begin
                who = bus.dbg_ack;
                chk("hold_order", 32'(who), fixedPat ? 32'(got % 5 == 4) : 32'(expSeq[got]));
                if (last >= 0) chk("hold_spacing", 32'(k - last), 32'd3);
                last = k;
                got++;
                if (who) refMem[dA[7:0]] = dD;
                else     refMem[cA[7:0]] = cD;
                if (got == n) begin
                    drivePort(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
                    drivePort(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
                end
            end
        end
        drivePort(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drivePort(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("hold_count", 32'(got), 32'(n));
        tick();
        chk("hold_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int ackSeen;
        int sel;
        vectors = 0; miscompares = 0;
        mStarve = 0; expCpu = '0; expDbg = '0;
        for (int i = 0; i < 256; i++) refMem[i] = initVal(8'(i));
        drivePort(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drivePort(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_mem", {28'd0, bus.mem_en, bus.mem_we, bus.cpu_ack, bus.dbg_ack}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // CPU write, then debug preload and CPU read with latency 3
        singleTxn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        singleTxn(1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0);
        singleTxn(1'b0, 1'b0, 32'h40, 32'd0, 1'b0);
        chk("t2_cpu_rdata", bus.cpu_rdata, 32'h1234_5678);
        singleTxn(1'b1, 1'b1, 32'h44, 32'hA5A5_A5A5, 1'b0);
        chk("t2_cpu_rdata_held", bus.cpu_rdata, 32'h1234_5678);

        // simultaneous requests: CPU first, debug at next IDLE reads CPU's store
        pairRound(1'b1, 1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, 1'b0, 32'h30, 32'd0);
        chk("t3_dbg_sees_cpu_write", bus.dbg_rdata, 32'h0BAD_F00D);

        // both held continuously: C,C,C,C,D repeating
        holdBoth(10, 32'h20, 32'h1111_2222, 32'h24, 32'h3333_4444, 1'b1);

        // reset during WAIT of a CPU read
        drivePort(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
        tick();
        chk("t5_access", 32'(bus.mem_en), 32'd1);
        tick();
        chk("t5_wait", {30'd0, bus.busy, bus.mem_en}, 32'd2);
        rst = 1'b1;
        drivePort(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_mem_en", 32'(bus.mem_en), 32'd0);
        chk("t5_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        chk("t5_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("t5_owner", 32'(bus.owner), 32'd0);
        rst = 1'b0;
        mStarve = 0; expCpu = '0; expDbg = '0;
        ackSeen = 0;
        repeat (6) begin
            tick();
            if (bus.cpu_ack || bus.dbg_ack) ackSeen++;
        end
        chk("t5_no_ack", 32'(ackSeen), 32'd0);
        singleTxn(1'b0, 1'b0, 32'h40, 32'd0, 1'b0);
        chk("t5_fresh_read", bus.cpu_rdata, 32'h1234_5678);

        // CPU address changes during WAIT: data must come from the latched address
        singleTxn(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 1'b0);
        singleTxn(1'b0, 1'b0, 32'h40, 32'd0, 1'b1);
        chk("t6_rdata_0x40", bus.cpu_rdata, 32'h1234_5678);

        // random single transactions
        for (int i = 0; i < 24; i++) begin
            singleTxn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 63)) << 2, $urandom, 1'b0);
        end

        // random contention rounds
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(1, 3);
            pairRound(sel[0], sel[1],
                      1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                      1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        end

        // random-length continuous contention against the model
        for (int i = 0; i < 2; i++) begin
            holdBoth($urandom_range(6, 14), 32'($urandom_range(0, 63)) << 2, $urandom,
                     32'($urandom_range(0, 63)) << 2, $urandom, 1'b0);
        end

        // read back a few addresses from each port to confirm memory contents
        for (int i = 0; i < 6; i++) begin
            singleTxn(1'(i % 2), 1'b0, 32'($urandom_range(0, 63)) << 2, 32'd0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
